// File: rtl/seven_seg_scan_if.sv
// Image-load handshake between a display-image producer (master) and seven_seg_scan (slave).
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic                    load_blank;

  modport master (output load_valid, load_data, load_dp, load_blank, input load_ready);
  modport slave  (input load_valid, load_data, load_dp, load_blank, output load_ready);
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with double-buffered image and leading-zero blanking.
// Optional anti-ghosting dead time at the start of each slot: define SEVEN_SEG_GHOST_BLANK_EN.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int COM_ANODE   = 1,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_if.slave       load,
  output logic [6:0]            segout,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digsel
);
  localparam logic        INV       = (COM_ANODE == 0);
  localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);

  logic [15:0]             r_presc;
  logic [2:0]              r_idx;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_sh_blank;
  logic [4*NUM_DIGITS-1:0] r_dsp_data;
  logic [NUM_DIGITS-1:0]   r_dsp_dp;
  logic                    r_dsp_blank;
  logic [6:0]              r_segout_p1;
  logic                    r_dp_p1;
  logic [NUM_DIGITS-1:0]   r_digsel_p1;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_accept;
  logic [3:0]              w_nib;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  logic                    w_dig_en;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic [NUM_DIGITS-1:0]   w_onehot;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'b0111111;
      4'h1:    seg_decode = 7'b0000110;
      4'h2:    seg_decode = 7'b1011011;
      4'h3:    seg_decode = 7'b1001111;
      4'h4:    seg_decode = 7'b1100110;
      4'h5:    seg_decode = 7'b1101101;
      4'h6:    seg_decode = 7'b1111101;
      4'h7:    seg_decode = 7'b0000111;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1100111;
      4'hA:    seg_decode = 7'b1110111;
      4'hB:    seg_decode = 7'b1111100;
      4'hC:    seg_decode = 7'b0111001;
      4'hD:    seg_decode = 7'b1011110;
      4'hE:    seg_decode = 7'b1111001;
      default: seg_decode = 7'b1110001;
    endcase
  endfunction

  assign w_tick         = (r_presc == PRESC_MAX);
  assign w_wrap         = w_tick && (r_idx == LAST_IDX);
  assign load.load_ready = ~r_pending;
  assign w_accept       = load.load_valid && ~r_pending;
  assign w_nib          = r_dsp_data[{r_idx, 2'b00} +: 4];
  assign w_cur_dp       = r_dsp_dp[r_idx];
  assign w_cur_blank    = w_blank_mask[r_idx];
  assign w_onehot       = NUM_DIGITS'(1) << r_idx;

`ifdef SEVEN_SEG_GHOST_BLANK_EN
  assign w_dig_en = (r_presc >= 16'd8);
`else
  assign w_dig_en = 1'b1;
`endif

  // A digit is blanked when it and every digit above it are zero with no dp; digit 0 never blanks.
  always_comb begin
    w_blank_mask = '0;
    w_zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run      = w_zero_run && (r_dsp_data[4*i +: 4] == 4'd0) && !r_dsp_dp[i];
      w_blank_mask[i] = w_zero_run && r_dsp_blank;
    end
  end

  // p0: scan counters and image buffers; display only swaps at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= 1'b0;
      r_dsp_data  <= '0;
      r_dsp_dp    <= '0;
      r_dsp_blank <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      if (w_wrap && r_pending) begin
        r_dsp_data  <= r_sh_data;
        r_dsp_dp    <= r_sh_dp;
        r_dsp_blank <= r_sh_blank;
      end
      if (w_accept) begin
        r_sh_data  <= load.load_data;
        r_sh_dp    <= load.load_dp;
        r_sh_blank <= load.load_blank;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // p1: registered, polarity-adjusted display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segout_p1 <= {7{INV}};
      r_dp_p1     <= INV;
      r_digsel_p1 <= {NUM_DIGITS{INV}};
    end else begin
      r_segout_p1 <= (w_cur_blank ? 7'd0 : seg_decode(w_nib)) ^ {7{INV}};
      r_dp_p1     <= (w_cur_dp && !w_cur_blank) ^ INV;
      r_digsel_p1 <= (w_dig_en ? w_onehot : '0) ^ {NUM_DIGITS{INV}};
    end
  end

  assign segout = r_segout_p1;
  assign dp_out = r_dp_p1;
  assign digsel = r_digsel_p1;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 4 digits, 16-cycle slots, both output polarities side by side.
module tb_seven_seg_scan;
`ifdef SEVEN_SEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dpin = '0;
  logic        blank = 1'b0;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] dig_a, dig_b;

  seven_seg_scan_if #(.NUM_DIGITS(4)) if_a ();
  seven_seg_scan_if #(.NUM_DIGITS(4)) if_b ();

  assign if_a.load_valid = valid;
  assign if_a.load_data  = data;
  assign if_a.load_dp    = dpin;
  assign if_a.load_blank = blank;
  assign if_b.load_valid = valid;
  assign if_b.load_data  = data;
  assign if_b.load_dp    = dpin;
  assign if_b.load_blank = blank;

  seven_seg_scan #(.NUM_DIGITS(4), .COM_ANODE(1), .REFRESH_DIV(16)) dut_a (
    .clk(clk), .rst(rst), .load(if_a), .segout(seg_a), .dp_out(dp_a), .digsel(dig_a));
  seven_seg_scan #(.NUM_DIGITS(4), .COM_ANODE(0), .REFRESH_DIV(16)) dut_b (
    .clk(clk), .rst(rst), .load(if_b), .segout(seg_b), .dp_out(dp_b), .digsel(dig_b));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] es, input logic ed, input logic [3:0] eg);
    logic [11:0] exp_a;
    exp_a = {es, ed, eg};
    checks++;
    assert ({seg_a, dp_a, dig_a} === exp_a) else begin
      errors++;
      $error("FAIL %s(ca1): observed %b required %b", tag, {seg_a, dp_a, dig_a}, exp_a);
    end
    checks++;
    assert ({seg_b, dp_b, dig_b} === ~exp_a) else begin
      errors++;
      $error("FAIL %s(ca0): observed %b required %b", tag, {seg_b, dp_b, dig_b}, ~exp_a);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic er);
    checks++;
    assert ({if_a.load_ready, if_b.load_ready} === {er, er}) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, {if_a.load_ready, if_b.load_ready}, {er, er});
    end
  endtask

  // Sample mid-slot (prescaler 10) of digit d in frame f.
  task automatic slot(input string tag, input int f, input int d, input logic [6:0] es, input logic ed);
    wait_cyc(64*f + 16*d + 11);
    chk(tag, es, ed, 4'b0001 << d);
  endtask

  // Sample digit d in frame f at prescaler value p.
  task automatic gslot(input string tag, input int f, input int d, input int p, input logic [6:0] es);
    wait_cyc(64*f + 16*d + p + 1);
    chk(tag, es, 1'b0, (GHOST && p < 8) ? 4'b0000 : (4'b0001 << d));
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic b);
    data = d; dpin = p; blank = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 7'b0000000, 1'b0, 4'b0000);
    chk_rdy("reset_ready", 1'b1);
    rst = 1'b0;

    wait_cyc(1);
    chk("first_digit0", 7'b0111111, 1'b0, GHOST ? 4'b0000 : 4'b0001);

    wait_cyc(5);
    offer(16'h12AF, 4'b0010, 1'b0);
    chk_rdy("pending_ready", 1'b0);
    slot("pre_boundary_d1", 0, 1, 7'b0111111, 1'b0);

    wait_cyc(30);
    chk_rdy("backpressure_ready", 1'b0);
    offer(16'h3333, 4'b0000, 1'b0);

    wait_cyc(64);
    chk("wrap_edge_old_d3", 7'b0111111, 1'b0, 4'b1000);
    chk_rdy("ready_after_wrap", 1'b1);
    wait_cyc(65);
    chk("new_d0_first", 7'b1110001, 1'b0, GHOST ? 4'b0000 : 4'b0001);

    wait_cyc(69);
    offer(16'h3333, 4'b0000, 1'b0);
    slot("img_d0_F", 1, 0, 7'b1110001, 1'b0);
    slot("img_d1_A_dp", 1, 1, 7'b1110111, 1'b1);
    slot("img_d2_2", 1, 2, 7'b1011011, 1'b0);
    slot("img_d3_1", 1, 3, 7'b0000110, 1'b0);
    slot("bp_accepted_d0", 2, 0, 7'b1001111, 1'b0);

    wait_cyc(191);
    offer(16'h5555, 4'b0000, 1'b0);
    chk_rdy("boundary_load_pending", 1'b0);
    slot("boundary_hold_d0", 3, 0, 7'b1001111, 1'b0);
    slot("boundary_hold_d3", 3, 3, 7'b1001111, 1'b0);
    slot("boundary_show_d0", 4, 0, 7'b1101101, 1'b0);

    wait_cyc(270);
    offer(16'h0040, 4'b0000, 1'b1);
    slot("boundary_show_d2", 4, 2, 7'b1101101, 1'b0);
    slot("lz40_d0", 5, 0, 7'b0111111, 1'b0);

    wait_cyc(335);
    offer(16'h0000, 4'b0000, 1'b1);
    slot("lz40_d1", 5, 1, 7'b1100110, 1'b0);
    slot("lz40_d2_blank", 5, 2, 7'b0000000, 1'b0);
    slot("lz40_d3_blank", 5, 3, 7'b0000000, 1'b0);
    slot("lz00_d0", 6, 0, 7'b0111111, 1'b0);
    gslot("dead_p3", 6, 1, 3, 7'b0000000);
    gslot("dead_p7", 6, 1, 7, 7'b0000000);
    gslot("live_p8", 6, 1, 8, 7'b0000000);
    slot("lz00_d3_blank", 6, 3, 7'b0000000, 1'b0);

    wait_cyc(445);
    offer(16'h8888, 4'b1111, 1'b0);
    chk_rdy("pending_before_rst", 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_midscan_async", 7'b0000000, 1'b0, 4'b0000);
    chk_rdy("rst_midscan_ready", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    slot("after_rst_d0", 0, 0, 7'b0111111, 1'b0);
    slot("discarded_img_d2", 1, 2, 7'b0111111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter COM_ANODE, default 1, output polarity select: 1 = uninverted, 0 = inverted.
REQ-003 SHALL have parameter REFRESH_DIV, default 1000, clk cycles per digit slot (legal range 16..65535).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 SHALL have port load_valid, input, 1 bit, new display image offered.
REQ-007 SHALL have port load_ready, output, 1 bit, block can accept an image.
REQ-008 SHALL have port load_data, input, 4*NUM_DIGITS bits, hex nibble per digit; digit i is at bits [4i+3:4i], and digit 0 is least significant.
REQ-009 SHALL have port load_dp, input, NUM_DIGITS bits, decimal point per digit.
REQ-010 SHALL have port load_blank, input, 1 bit, leading-zero suppression request for this image.
REQ-011 SHALL have port segout, output, 7 bits, segments g..a, polarity-adjusted.
REQ-012 SHALL have port dp_out, output, 1 bit, decimal point, polarity-adjusted.
REQ-013 SHALL have port digsel, output, NUM_DIGITS bits, one-hot digit enable, polarity-adjusted.

Function
REQ-014 SHALL decode nibbles with segment order g..a, 1 = lit before polarity: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-015 SHALL, when COM_ANODE=1, drive segout, dp_out and digsel uninverted (1 = lit or enabled), and SHALL invert all three when COM_ANODE=0.
REQ-016 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; a tick occurs in the cycle the prescaler equals REFRESH_DIV-1.
REQ-017 SHALL advance the digit index on each tick, 0 to NUM_DIGITS-1 and then wrapping to 0; with NUM_DIGITS=1 the index stays 0.
REQ-018 SHALL register segout, dp_out and digsel, so outputs reflect the index and prescaler values of the previous cycle (one-cycle latency).
REQ-019 SHALL hold a shadow image and a display image (nibbles, dp bits, blank flag), plus a pending flag.
REQ-020 SHALL drive load_ready = NOT pending, combinationally from the pending register.
REQ-021 SHALL, on load_valid AND load_ready, capture load_data, load_dp and load_blank into the shadow image and set pending.
REQ-022 SHALL, on a tick where the index wraps from NUM_DIGITS-1 to 0 (frame boundary) with pending=1, copy shadow to display and clear pending in the same edge.
REQ-023 SHALL ensure a load accepted in the frame-boundary cycle (pending was 0) goes to shadow only, with display updating at the next frame boundary; no image is lost or torn.
REQ-024 SHALL ensure the display image changes only at frame boundaries.
REQ-025 SHALL, when the display blank flag is 1, blank digit i (segout and dp_out off) when every digit j >= i has nibble 0 and dp 0; digit 0 SHALL never be blanked.
REQ-026 SHALL keep a blanked digit's digsel asserted, with its segments off.

Reset
REQ-027 SHALL, on rst assertion, immediately clear the prescaler, digit index, pending, shadow and display images (all nibbles 0, dp 0, blank 0).
REQ-028 SHALL, during and after reset, drive digsel all-inactive, segout all-off, dp_out off and load_ready 1, per polarity.
REQ-029 SHALL, when rst asserts mid-frame or with a load pending, discard the pending image.
REQ-030 SHALL, in the first cycle after rst deassertion, present digit 0 showing "0" on the next edge.

Configuration
REQ-031 SHALL, when macro SEVEN_SEG_GHOST_BLANK_EN is defined, hold digsel all-inactive while prescaler < 8 within every slot (anti-ghosting dead time); segout still updates.
REQ-032 SHALL, when SEVEN_SEG_GHOST_BLANK_EN is undefined, keep digsel asserted for the whole slot, with no dead time.

Verification
REQ-033 SHALL cover reset: defaults, rst pulse mid-scan -> digsel inactive within the same cycle, load_ready=1, then digit 0 shows 0111111.
REQ-034 SHALL cover image update: NUM_DIGITS=4, REFRESH_DIV=16, load 0x12AF with dp=0010 -> segout sequence 1110001, 1110111 (dp on), 1011011, 0000110; change occurs only after a frame boundary.
REQ-035 SHALL cover back-pressure: second load_valid while pending -> load_ready=0 and no capture; accepted after the boundary.
REQ-036 SHALL cover the boundary-cycle load: load 0x5555 in the wrap cycle -> displayed exactly one frame later.
REQ-037 SHALL cover leading-zero suppression: blank=1, data 0x0040 -> digits 3 and 2 blank, digits 1 and 0 show 4 and 0; data 0x0000 -> only digit 0 lit.
REQ-038 SHALL cover polarity and config: COM_ANODE=0 -> all outputs inverted; with SEVEN_SEG_GHOST_BLANK_EN -> digsel inactive for 8 cycles of each 16-cycle slot.
